// File: rtl/fetch_queue.sv
// Instruction fetch front end: drives the icache at the current PC and buffers
// returned {instruction, pc} pairs in a small circular queue for decode.
`timescale 1ns/1ps
module fetch_queue #(
  parameter int                WORD_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     RST,
  output logic                     imemREN,
  output logic [WORD_W-1:0]        imemaddr,
  input  logic                     ihit,
  input  logic [WORD_W-1:0]        imemload,
  input  logic                     redirect_en,
  input  logic [WORD_W-1:0]        redirect_pc,
  input  logic                     halt,
  output logic                     fetch_valid,
  output logic [WORD_W-1:0]        fetch_instr,
  output logic [WORD_W-1:0]        fetch_pc,
  input  logic                     fetch_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WORD_W-1:0] pc;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [WORD_W-1:0] instr_mem [DEPTH];
  logic [WORD_W-1:0] pc_mem    [DEPTH];
  logic              push;
  logic              pop;

  // RST gates the request so imemREN is low throughout reset, not just after it.
  assign imemREN     = !RST && !halt && (count < DEPTH_C) && !redirect_en;
  assign imemaddr    = pc;
  assign fetch_valid = (count != '0);
  assign fetch_instr = instr_mem[head];
  assign fetch_pc    = pc_mem[head];

  assign push = imemREN && ihit;
  assign pop  = fetch_valid && fetch_ready && !redirect_en;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc    <= RESET_PC;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (redirect_en) begin
      // Targets are word aligned; low two bits of the redirect are dropped.
      pc    <= redirect_pc & ~WORD_W'(3);
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
        pc   <= pc + WORD_W'(4);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage is never reset; the head is only meaningful while fetch_valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      instr_mem[tail] <= imemload;
      pc_mem[tail]    <= pc;
    end
  end

endmodule
